game_state_controller: RTL and testbench
========================================

Name: game_state_controller

Overview:
Parametrised game-flow controller for the Frogger top level. It replaces the fixed two-state IDLE/RUNNING machine and 3-bit life shifter with a four-state machine. It adds configurable lives, a post-hit respawn window, a timed game-over hold, level tracking and an optional bonus life. It sits between the collision/character-control blocks and the LED, sprite and obstacle blocks.

Parameters:
NUM_LIVES, 3, lives at game start (1..8); width of o_Lives
RESPAWN_CYCLES, 25000000, clocks spent in RESPAWN after a hit (>=1)
GAMEOVER_CYCLES, 50000000, clocks spent in GAME_OVER before IDLE (>=1)
LEVEL_WIDTH, 4, width of o_Level
MAX_LEVEL, 9, saturation value of o_Level
BONUS_LIFE_EN, 1, 1 = each accepted level-up restores one lost life

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Start  in  1  debounced start request (all switches pressed), level
i_Has_Collided  in  1  collision flag, level; may stay high for many cycles
i_Level_Up  in  1  one-cycle pulse when the frog reaches the far side
o_State  out  2  0 IDLE, 1 RUNNING, 2 RESPAWN, 3 GAME_OVER
o_Game_Active  out  1  high only in RUNNING
o_Lives  out  NUM_LIVES  thermometer code of remaining lives, LSB-aligned
o_Level  out  LEVEL_WIDTH  current level, starts at 0
o_Frog_Reset  out  1  one-cycle pulse: return the frog to its base position
o_Game_Over  out  1  one-cycle pulse on entry to GAME_OVER

Behaviour:
- Reset (i_Rst_L low, asynchronous): state IDLE, o_Lives all ones, o_Level 0, pulses 0, timer 0, edge registers 0. All outputs are registered.
- Edge detection: registered previous values of i_Start and i_Has_Collided. "Start edge" = i_Start & ~prev. "Hit edge" = i_Has_Collided & ~prev. Previous values update every cycle in every state.
- IDLE: on a start edge, reload o_Lives to all ones, clear o_Level to 0, pulse o_Frog_Reset, and go to RUNNING next cycle.
  - A level-held i_Start coming out of reset or out of GAME_OVER does not restart the game. A fresh rising edge is required.
- RUNNING:
  - On a hit edge, shift o_Lives right by one.
    - If o_Lives was 1 before the shift: go to GAME_OVER and pulse o_Game_Over.
    - Otherwise: go to RESPAWN, pulse o_Frog_Reset, load the timer with RESPAWN_CYCLES-1.
  - Else on i_Level_Up:
    - o_Level increments, saturating at MAX_LEVEL.
    - If BONUS_LIFE_EN and o_Lives is not all ones, o_Lives becomes (o_Lives<<1)|1.
    - State stays RUNNING.
  - A hit edge and i_Level_Up in the same cycle: the hit wins, and the level-up is dropped.
- RESPAWN:
  - i_Has_Collided and i_Level_Up are ignored.
  - The timer decrements each cycle. At 0, go to RUNNING.
  - A collision level still high on return does not cost a life; only a new rising edge does.
- GAME_OVER:
  - Load the timer with GAMEOVER_CYCLES-1 on entry and decrement it each cycle. At 0, go to IDLE.
  - o_Lives holds 0 and o_Level holds its final value until the next start edge.
  - All inputs except reset are ignored.
- Pulses: o_Frog_Reset and o_Game_Over are high for exactly one cycle, registered alongside the state transition.
- Timer: width is clog2(max(RESPAWN_CYCLES, GAMEOVER_CYCLES)), minimum 1. No wrap: the timer is only decremented when non-zero.
- Latency: input to state/output change is 1 clock.
- Reset mid-operation: immediate return to the reset values from any state, including mid-timer.

Test Plan:
(Params for 1–5: NUM_LIVES=3, RESPAWN_CYCLES=4, GAMEOVER_CYCLES=6, MAX_LEVEL=9, BONUS_LIFE_EN=1.)
1. Reset with i_Start held high, release reset -> stays IDLE, o_Lives=3'b111. Drop i_Start, raise it -> next cycle o_State=1, o_Frog_Reset pulses once.
2. RUNNING, one hit with i_Has_Collided held high for 20 cycles -> o_Lives=3'b011, o_State=2 for exactly 4 cycles then 1, only one life lost. Lower and re-raise collision -> o_Lives=3'b001.
3. Three separate hits -> 3'b111→011→001→000. o_Game_Over pulses on the third hit. o_State=3 for 6 cycles, then 0. A start edge then gives lives 111 and level 0.
4. After one hit (o_Lives=011), pulse i_Level_Up -> o_Level=1, o_Lives=111. Ten further pulses -> o_Level saturates at 9.
5. i_Level_Up and a hit edge in the same cycle with o_Lives=111 -> o_Lives=011, o_Level unchanged, o_State=2.
6. Assert i_Rst_L low asynchronously mid-RESPAWN -> outputs reach reset values without a clock edge. Rerun scenario 3 with NUM_LIVES=5 -> five hits to GAME_OVER.

Source files
------------

// File: rtl/game_state_controller_if.sv
// Game-flow controller bundle: player/collision inputs and
// state, lives, level and pulse outputs.
interface game_state_controller_if #(
  parameter int NUM_LIVES   = 3,
  parameter int LEVEL_WIDTH = 4
);
  logic                   i_Start;
  logic                   i_Has_Collided;
  logic                   i_Level_Up;
  logic [1:0]             o_State;
  logic                   o_Game_Active;
  logic [NUM_LIVES-1:0]   o_Lives;
  logic [LEVEL_WIDTH-1:0] o_Level;
  logic                   o_Frog_Reset;
  logic                   o_Game_Over;

  modport master (
    output i_Start,
    output i_Has_Collided,
    output i_Level_Up,
    input  o_State,
    input  o_Game_Active,
    input  o_Lives,
    input  o_Level,
    input  o_Frog_Reset,
    input  o_Game_Over
  );

  modport slave (
    input  i_Start,
    input  i_Has_Collided,
    input  i_Level_Up,
    output o_State,
    output o_Game_Active,
    output o_Lives,
    output o_Level,
    output o_Frog_Reset,
    output o_Game_Over
  );
endinterface

// File: rtl/game_state_controller.sv
// Frogger game flow: IDLE/RUNNING/RESPAWN/GAME_OVER with
// lives, respawn and game-over timers, levels and bonus life.
module game_state_controller #(
  parameter int NUM_LIVES       = 3,
  parameter int RESPAWN_CYCLES  = 25000000,
  parameter int GAMEOVER_CYCLES = 50000000,
  parameter int LEVEL_WIDTH     = 4,
  parameter int MAX_LEVEL       = 9,
  parameter bit BONUS_LIFE_EN   = 1'b1
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  game_state_controller_if.slave bus
);

  localparam int MAXC =
    (RESPAWN_CYCLES > GAMEOVER_CYCLES) ?
    RESPAWN_CYCLES : GAMEOVER_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] RESP_LOAD =
    TW'(RESPAWN_CYCLES - 1);
  localparam logic [TW-1:0] OVER_LOAD =
    TW'(GAMEOVER_CYCLES - 1);
  localparam logic [NUM_LIVES-1:0] FULL = '1;
  localparam logic [NUM_LIVES-1:0] ONE =
    NUM_LIVES'(1);
  localparam logic [LEVEL_WIDTH-1:0] LMAX =
    LEVEL_WIDTH'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LIVES-1:0]   lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   frog_q, frog_d;
  logic                   over_q, over_d;
  logic                   prev_start, prev_hit;
  logic                   armed;

  logic start_edge, hit_edge, timer_zero, last_life;

  // A start held through reset release is not a fresh press:
  // armed stays low for the first clock so prev_start can latch.
  assign start_edge = armed & bus.i_Start & ~prev_start;
  assign hit_edge   = bus.i_Has_Collided & ~prev_hit;
  assign timer_zero = (timer_q == '0);
  assign last_life  = (lives_q == ONE);

  // State, counters, pulses and edge history registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      lives_q    <= FULL;
      level_q    <= '0;
      timer_q    <= '0;
      frog_q     <= 1'b0;
      over_q     <= 1'b0;
      prev_start <= 1'b0;
      prev_hit   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      frog_q     <= frog_d;
      over_q     <= over_d;
      prev_start <= bus.i_Start;
      prev_hit   <= bus.i_Has_Collided;
      armed      <= 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_edge) state_d = RUNNING;
      RUNNING:
        if (hit_edge)
          state_d = last_life ? GAME_OVER : RESPAWN;
      RESPAWN:
        if (timer_zero) state_d = RUNNING;
      GAME_OVER:
        if (timer_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lives, level, timer and pulse updates for the next clock
  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    timer_d = timer_q;
    frog_d  = 1'b0;
    over_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          lives_d = FULL;
          level_d = '0;
          frog_d  = 1'b1;
        end
      end
      RUNNING: begin
        if (hit_edge) begin
          lives_d = lives_q >> 1;
          if (last_life) begin
            over_d  = 1'b1;
            timer_d = OVER_LOAD;
          end else begin
            frog_d  = 1'b1;
            timer_d = RESP_LOAD;
          end
        end else if (bus.i_Level_Up) begin
          if (level_q < LMAX)
            level_d = level_q + LEVEL_WIDTH'(1);
          if (BONUS_LIFE_EN && lives_q != FULL)
            lives_d = (lives_q << 1) | ONE;
        end
      end
      RESPAWN, GAME_OVER: begin
        if (!timer_zero) timer_d = timer_q - TW'(1);
      end
      default: ;
    endcase
  end

  assign bus.o_State       = state_q;
  assign bus.o_Game_Active = (state_q == RUNNING);
  assign bus.o_Lives       = lives_q;
  assign bus.o_Level       = level_q;
  assign bus.o_Frog_Reset  = frog_q;
  assign bus.o_Game_Over   = over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: 3-life and
// 5-life instances with short respawn/game-over timers.
module tb_game_state_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  game_state_controller_if #(
    .NUM_LIVES(3), .LEVEL_WIDTH(4)) ifa ();
  game_state_controller_if #(
    .NUM_LIVES(5), .LEVEL_WIDTH(4)) ifb ();

  game_state_controller #(
    .NUM_LIVES(3), .RESPAWN_CYCLES(4),
    .GAMEOVER_CYCLES(6), .LEVEL_WIDTH(4),
    .MAX_LEVEL(9), .BONUS_LIFE_EN(1'b1)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(ifa.slave)
  );

  game_state_controller #(
    .NUM_LIVES(5), .RESPAWN_CYCLES(4),
    .GAMEOVER_CYCLES(6), .LEVEL_WIDTH(4),
    .MAX_LEVEL(9), .BONUS_LIFE_EN(1'b1)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(ifb.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    ifa.i_Start = 1'b0;
    ifa.i_Has_Collided = 1'b0;
    ifa.i_Level_Up = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    ifa.i_Start = 1'b1;
    tick();
    ifa.i_Start = 1'b0;
  endtask

  task automatic test_reset();
    ifa.i_Start = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (ifa.o_State !== 2'd0 || ifa.o_Lives !== 3'b111 ||
        ifa.o_Level !== 4'd0 || ifa.o_Frog_Reset !== 1'b0 ||
        ifa.o_Game_Over !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vals: st=%0d lives=%b lvl=%0d fr=%b go=%b, need 0 111 0 0 0",
               ifa.o_State, ifa.o_Lives, ifa.o_Level,
               ifa.o_Frog_Reset, ifa.o_Game_Over);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (ifa.o_State !== 2'd0 || ifa.o_Lives !== 3'b111) begin
      miscompares++;
      $display("FAIL held_start: st=%0d lives=%b, need 0 111",
               ifa.o_State, ifa.o_Lives);
    end
    ifa.i_Start = 1'b0;
    tick();
    ifa.i_Start = 1'b1;
    tick();
    vectors++;
    if (ifa.o_State !== 2'd1 || ifa.o_Frog_Reset !== 1'b1 ||
        ifa.o_Game_Active !== 1'b1) begin
      miscompares++;
      $display("FAIL start_edge: st=%0d fr=%b act=%b, need 1 1 1",
               ifa.o_State, ifa.o_Frog_Reset, ifa.o_Game_Active);
    end
    tick();
    vectors++;
    if (ifa.o_State !== 2'd1 || ifa.o_Frog_Reset !== 1'b0) begin
      miscompares++;
      $display("FAIL frog_pulse_len: st=%0d fr=%b, need 1 0",
               ifa.o_State, ifa.o_Frog_Reset);
    end
    ifa.i_Start = 1'b0;
  endtask

  task automatic test_hold_collision();
    int n;
    ifa.i_Has_Collided = 1'b1;
    tick();
    vectors++;
    if (ifa.o_State !== 2'd2 || ifa.o_Lives !== 3'b011 ||
        ifa.o_Frog_Reset !== 1'b1) begin
      miscompares++;
      $display("FAIL first_hit: st=%0d lives=%b fr=%b, need 2 011 1",
               ifa.o_State, ifa.o_Lives, ifa.o_Frog_Reset);
    end
    n = 1;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (ifa.o_State == 2'd2) n++;
    end
    vectors++;
    if (n != 4 || ifa.o_Lives !== 3'b011 ||
        ifa.o_State !== 2'd1) begin
      miscompares++;
      $display("FAIL respawn_len: cycles=%0d lives=%b st=%0d, need 4 011 1",
               n, ifa.o_Lives, ifa.o_State);
    end
    ifa.i_Has_Collided = 1'b0;
    tick();
    ifa.i_Has_Collided = 1'b1;
    tick();
    vectors++;
    if (ifa.o_Lives !== 3'b001 || ifa.o_State !== 2'd2) begin
      miscompares++;
      $display("FAIL second_hit: lives=%b st=%0d, need 001 2",
               ifa.o_Lives, ifa.o_State);
    end
    ifa.i_Has_Collided = 1'b0;
  endtask

  task automatic test_game_over();
    logic [2:0] exp;
    int n;
    reset_and_start();
    ifa.i_Level_Up = 1'b1;
    tick();
    ifa.i_Level_Up = 1'b0;
    vectors++;
    if (ifa.o_Level !== 4'd1 || ifa.o_Lives !== 3'b111) begin
      miscompares++;
      $display("FAIL lvl_full_lives: lvl=%0d lives=%b, need 1 111",
               ifa.o_Level, ifa.o_Lives);
    end
    for (int k = 0; k < 3; k++) begin
      ifa.i_Has_Collided = 1'b1;
      tick();
      exp = 3'b111 >> (k + 1);
      vectors++;
      if (ifa.o_Lives !== exp) begin
        miscompares++;
        $display("FAIL hit_lives k=%0d: lives=%b, need %b",
                 k, ifa.o_Lives, exp);
      end
      ifa.i_Has_Collided = 1'b0;
      if (k < 2) begin
        for (int i = 0; i < 20 && ifa.o_State != 2'd1; i++)
          tick();
        vectors++;
        if (ifa.o_State !== 2'd1) begin
          miscompares++;
          $display("FAIL return_running k=%0d: st=%0d, need 1",
                   k, ifa.o_State);
        end
      end
    end
    vectors++;
    if (ifa.o_State !== 2'd3 || ifa.o_Game_Over !== 1'b1) begin
      miscompares++;
      $display("FAIL over_entry: st=%0d go=%b, need 3 1",
               ifa.o_State, ifa.o_Game_Over);
    end
    ifa.i_Start = 1'b1;
    tick();
    vectors++;
    if (ifa.o_Game_Over !== 1'b0 || ifa.o_State !== 2'd3 ||
        ifa.o_Level !== 4'd1) begin
      miscompares++;
      $display("FAIL over_hold: go=%b st=%0d lvl=%0d, need 0 3 1",
               ifa.o_Game_Over, ifa.o_State, ifa.o_Level);
    end
    n = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.o_State != 2'd3) break;
      n++;
    end
    vectors++;
    if (n != 6 || ifa.o_State !== 2'd0 ||
        ifa.o_Lives !== 3'b000) begin
      miscompares++;
      $display("FAIL over_len: cycles=%0d st=%0d lives=%b, need 6 0 000",
               n, ifa.o_State, ifa.o_Lives);
    end
    tick();
    vectors++;
    if (ifa.o_State !== 2'd0) begin
      miscompares++;
      $display("FAIL held_start_after_over: st=%0d, need 0",
               ifa.o_State);
    end
    ifa.i_Start = 1'b0;
    tick();
    ifa.i_Start = 1'b1;
    tick();
    ifa.i_Start = 1'b0;
    vectors++;
    if (ifa.o_State !== 2'd1 || ifa.o_Lives !== 3'b111 ||
        ifa.o_Level !== 4'd0) begin
      miscompares++;
      $display("FAIL restart: st=%0d lives=%b lvl=%0d, need 1 111 0",
               ifa.o_State, ifa.o_Lives, ifa.o_Level);
    end
  endtask

  task automatic test_level_up();
    reset_and_start();
    ifa.i_Has_Collided = 1'b1;
    tick();
    ifa.i_Has_Collided = 1'b0;
    for (int i = 0; i < 20 && ifa.o_State != 2'd1; i++)
      tick();
    ifa.i_Level_Up = 1'b1;
    tick();
    ifa.i_Level_Up = 1'b0;
    vectors++;
    if (ifa.o_Level !== 4'd1 || ifa.o_Lives !== 3'b111 ||
        ifa.o_State !== 2'd1) begin
      miscompares++;
      $display("FAIL bonus_life: lvl=%0d lives=%b st=%0d, need 1 111 1",
               ifa.o_Level, ifa.o_Lives, ifa.o_State);
    end
    for (int i = 0; i < 10; i++) begin
      ifa.i_Level_Up = 1'b1;
      tick();
      ifa.i_Level_Up = 1'b0;
      tick();
    end
    vectors++;
    if (ifa.o_Level !== 4'd9 || ifa.o_Lives !== 3'b111) begin
      miscompares++;
      $display("FAIL level_sat: lvl=%0d lives=%b, need 9 111",
               ifa.o_Level, ifa.o_Lives);
    end
  endtask

  task automatic test_same_cycle();
    ifa.i_Level_Up = 1'b1;
    ifa.i_Has_Collided = 1'b1;
    tick();
    ifa.i_Level_Up = 1'b0;
    vectors++;
    if (ifa.o_Lives !== 3'b011 || ifa.o_Level !== 4'd9 ||
        ifa.o_State !== 2'd2) begin
      miscompares++;
      $display("FAIL hit_wins: lives=%b lvl=%0d st=%0d, need 011 9 2",
               ifa.o_Lives, ifa.o_Level, ifa.o_State);
    end
    tick();
    ifa.i_Level_Up = 1'b1;
    tick();
    ifa.i_Level_Up = 1'b0;
    vectors++;
    if (ifa.o_Lives !== 3'b011 || ifa.o_State !== 2'd2) begin
      miscompares++;
      $display("FAIL respawn_ignores: lives=%b st=%0d, need 011 2",
               ifa.o_Lives, ifa.o_State);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ifa.o_State !== 2'd0 || ifa.o_Lives !== 3'b111 ||
        ifa.o_Level !== 4'd0 || ifa.o_Frog_Reset !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: st=%0d lives=%b lvl=%0d fr=%b, need 0 111 0 0",
               ifa.o_State, ifa.o_Lives, ifa.o_Level,
               ifa.o_Frog_Reset);
    end
    ifa.i_Has_Collided = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_five_lives();
    logic [4:0] exp;
    ifb.i_Start = 1'b1;
    tick();
    ifb.i_Start = 1'b0;
    vectors++;
    if (ifb.o_State !== 2'd1 || ifb.o_Lives !== 5'b11111) begin
      miscompares++;
      $display("FAIL b_start: st=%0d lives=%b, need 1 11111",
               ifb.o_State, ifb.o_Lives);
    end
    for (int k = 0; k < 5; k++) begin
      ifb.i_Has_Collided = 1'b1;
      tick();
      ifb.i_Has_Collided = 1'b0;
      exp = 5'b11111 >> (k + 1);
      vectors++;
      if (ifb.o_Lives !== exp ||
          ifb.o_Game_Over !== (k == 4)) begin
        miscompares++;
        $display("FAIL b_hit k=%0d: lives=%b go=%b, need %b %b",
                 k, ifb.o_Lives, ifb.o_Game_Over, exp, (k == 4));
      end
      if (k < 4)
        for (int i = 0; i < 20 && ifb.o_State != 2'd1; i++)
          tick();
    end
    vectors++;
    if (ifb.o_State !== 2'd3) begin
      miscompares++;
      $display("FAIL b_over: st=%0d, need 3", ifb.o_State);
    end
    for (int i = 0; i < 20 && ifb.o_State != 2'd0; i++)
      tick();
    vectors++;
    if (ifb.o_State !== 2'd0 || ifb.o_Lives !== 5'b00000) begin
      miscompares++;
      $display("FAIL b_idle: st=%0d lives=%b, need 0 00000",
               ifb.o_State, ifb.o_Lives);
    end
  endtask

  initial begin
    ifa.i_Start = 1'b0;
    ifa.i_Has_Collided = 1'b0;
    ifa.i_Level_Up = 1'b0;
    ifb.i_Start = 1'b0;
    ifb.i_Has_Collided = 1'b0;
    ifb.i_Level_Up = 1'b0;
    test_reset();
    test_hold_collision();
    test_game_over();
    test_level_up();
    test_same_cycle();
    test_async_reset();
    test_five_lives();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
